// File: rtl/sent_tx_frame_seq.sv
// SENT transmit frame sequencer: one-deep frame buffer, internal CRC, and a
// symbol-request stream (SYNC, STATUS, DATA, CRC, PAUSE) for the pulse generator.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame active; loads the holding buffer when it fills
// SYNC   | presenting the 56-tick calibration pulse
// STATUS | presenting the status/communication nibble
// DATA   | presenting data nibbles 0..len-1, CRC updated on accept
// CRC    | presenting the CRC nibble
// PAUSE  | presenting the pause pulse (fixed or constant frame length)
module sent_tx_frame_seq #(
   parameter int MAX_NIB = 6,
   parameter int TICK_W  = 10
) (
   input  logic                 clk_tx,
   input  logic                 reset_n_tx,
   input  logic                 frame_valid_i,
   output logic                 frame_ready_o,
   input  logic [4*MAX_NIB-1:0] frame_data_i,
   input  logic [2:0]           frame_len_i,
   input  logic [3:0]           status_i,
   input  logic [1:0]           pause_mode_i,
   input  logic [TICK_W-1:0]    pause_ticks_i,
   output logic                 sym_valid_o,
   input  logic                 sym_ready_i,
   output logic [2:0]           sym_kind_o,
   output logic [TICK_W-1:0]    sym_ticks_o,
   output logic                 busy_o,
   output logic                 frame_done_o,
   output logic                 err_len_o
);

   localparam int DW = 4 * MAX_NIB;

   localparam logic [3:0]        CRC_SEED   = 4'b0101;
   localparam logic [3:0]        MAX_LEN    = 4'(MAX_NIB);
   localparam logic [TICK_W-1:0] SYNC_TICKS = TICK_W'(56);
   localparam logic [TICK_W-1:0] MIN_TICKS  = TICK_W'(12);
   localparam logic [TICK_W:0]   MIN_EXT    = (TICK_W+1)'(12);

   localparam logic [2:0] K_SYNC   = 3'd0;
   localparam logic [2:0] K_STATUS = 3'd1;
   localparam logic [2:0] K_DATA   = 3'd2;
   localparam logic [2:0] K_CRC    = 3'd3;
   localparam logic [2:0] K_PAUSE  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_STATUS,
      S_DATA,
      S_CRC,
      S_PAUSE
   } state_t;

   function automatic logic [3:0] crc_nib(input logic [3:0] crc_in, input logic [3:0] nib);
      logic [3:0] c;
      logic       fb;
      c = crc_in;
      for (int b = 3; b >= 0; b--) begin
         fb = c[3] ^ nib[b];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'b1101 : 4'b0000);
      end
      return c;
   endfunction

   function automatic logic [TICK_W-1:0] nib_ticks(input logic [3:0] nib);
      return MIN_TICKS + {{(TICK_W-4){1'b0}}, nib};
   endfunction

   state_t              r_state;
   logic                r_hold_full;
   logic [DW-1:0]       r_hold_data;
   logic [2:0]          r_hold_len;
   logic [3:0]          r_hold_status;
   logic [1:0]          r_hold_mode;
   logic [TICK_W-1:0]   r_hold_pticks;
   logic [DW-1:0]       r_act_data;
   logic [2:0]          r_act_len;
   logic [3:0]          r_act_status;
   logic [1:0]          r_act_mode;
   logic [TICK_W-1:0]   r_act_pticks;
   logic [2:0]          r_nib_idx;
   logic [3:0]          r_crc;
   logic [TICK_W-1:0]   r_acc;

   logic                w_accept;
   logic                w_sym_acc;
   logic                w_hold_len_ok;
   logic                w_act_has_pause;
   logic                w_last_sym;
   logic                w_frame_end;
   logic                w_transfer;
   logic [DW-1:0]       w_data_shl;
   logic [3:0]          w_cur_nib;
   logic [3:0]          w_next_nib;
   logic [3:0]          w_crc_upd;
   logic [3:0]          w_crc_out;
   logic                w_nib_last;
   logic [TICK_W-1:0]   w_status_ticks;
   logic [TICK_W-1:0]   w_cur_ticks;
   logic [TICK_W-1:0]   w_next_ticks;
   logic [TICK_W-1:0]   w_crc_ticks;
   logic [TICK_W:0]     w_acc_min;
   logic [TICK_W-1:0]   w_const_pause;
   logic [TICK_W-1:0]   w_fixed_pause;
   logic [TICK_W-1:0]   w_pause_ticks;

   assign frame_ready_o   = reset_n_tx & ~r_hold_full;
   assign w_accept        = frame_valid_i & frame_ready_o;
   assign w_sym_acc       = sym_valid_o & sym_ready_i;
   assign w_hold_len_ok   = (r_hold_len != 3'd0) && ({1'b0, r_hold_len} <= MAX_LEN);
   assign w_act_has_pause = (r_act_mode == 2'b01) || (r_act_mode == 2'b10);
   assign w_last_sym      = (r_state == S_PAUSE) || ((r_state == S_CRC) && !w_act_has_pause);
   assign w_frame_end     = w_sym_acc && w_last_sym;
   // The holding buffer is drained either from IDLE or straight out of the
   // last symbol of the previous frame, which gives back-to-back frames.
   assign w_transfer      = r_hold_full && ((r_state == S_IDLE) || w_frame_end);

   // Data nibbles are consumed from the top of a shift register.
   assign w_data_shl      = r_act_data << 4;
   assign w_cur_nib       = r_act_data[DW-1 -: 4];
   assign w_next_nib      = w_data_shl[DW-1 -: 4];
   assign w_crc_upd       = crc_nib(r_crc, w_cur_nib);
   assign w_crc_out       = crc_nib(w_crc_upd, 4'h0);
   assign w_nib_last      = (r_nib_idx == (r_act_len - 3'd1));

   assign w_status_ticks  = nib_ticks(r_act_status);
   assign w_cur_ticks     = nib_ticks(w_cur_nib);
   assign w_next_ticks    = nib_ticks(w_next_nib);
   assign w_crc_ticks     = nib_ticks(w_crc_out);

   // Compare one bit wider so a frame already longer than L cannot wrap.
   assign w_acc_min       = {1'b0, r_acc} + MIN_EXT;
   assign w_const_pause   = ({1'b0, r_act_pticks} >= w_acc_min) ? (r_act_pticks - r_acc) : MIN_TICKS;
   assign w_fixed_pause   = (r_act_pticks < MIN_TICKS) ? MIN_TICKS : r_act_pticks;
   assign w_pause_ticks   = (r_act_mode == 2'b01) ? w_fixed_pause : w_const_pause;

   always_ff @(posedge clk_tx or negedge reset_n_tx) begin
      if (!reset_n_tx) begin
         r_hold_full   <= 1'b0;
         r_hold_data   <= '0;
         r_hold_len    <= '0;
         r_hold_status <= '0;
         r_hold_mode   <= '0;
         r_hold_pticks <= '0;
      end else if (w_accept) begin
         r_hold_full   <= 1'b1;
         r_hold_data   <= frame_data_i;
         r_hold_len    <= frame_len_i;
         r_hold_status <= status_i;
         r_hold_mode   <= pause_mode_i;
         r_hold_pticks <= pause_ticks_i;
      end else if (w_transfer) begin
         r_hold_full   <= 1'b0;
      end
   end

   always_ff @(posedge clk_tx or negedge reset_n_tx) begin
      if (!reset_n_tx) begin
         r_act_data   <= '0;
         r_act_len    <= '0;
         r_act_status <= '0;
         r_act_mode   <= '0;
         r_act_pticks <= '0;
      end else if (w_transfer) begin
         r_act_data   <= r_hold_data;
         r_act_len    <= r_hold_len;
         r_act_status <= r_hold_status;
         r_act_mode   <= r_hold_mode;
         r_act_pticks <= r_hold_pticks;
      end else if ((r_state == S_DATA) && w_sym_acc) begin
         r_act_data   <= w_data_shl;
      end
   end

   always_ff @(posedge clk_tx or negedge reset_n_tx) begin
      if (!reset_n_tx) begin
         r_state      <= S_IDLE;
         r_nib_idx    <= '0;
         r_crc        <= CRC_SEED;
         r_acc        <= '0;
         sym_valid_o  <= 1'b0;
         sym_kind_o   <= K_SYNC;
         sym_ticks_o  <= '0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
         err_len_o    <= 1'b0;
      end else begin
         frame_done_o <= w_frame_end;
         err_len_o    <= 1'b0;
         if (w_transfer) begin
            if (w_hold_len_ok) begin
               r_state     <= S_SYNC;
               r_nib_idx   <= '0;
               r_crc       <= CRC_SEED;
               r_acc       <= SYNC_TICKS;
               sym_valid_o <= 1'b1;
               sym_kind_o  <= K_SYNC;
               sym_ticks_o <= SYNC_TICKS;
               busy_o      <= 1'b1;
            end else begin
               r_state     <= S_IDLE;
               sym_valid_o <= 1'b0;
               busy_o      <= 1'b0;
               err_len_o   <= 1'b1;
            end
         end else if (w_frame_end) begin
            r_state     <= S_IDLE;
            sym_valid_o <= 1'b0;
            busy_o      <= 1'b0;
         end else if (w_sym_acc) begin
            case (r_state)
               S_SYNC: begin
                  r_state     <= S_STATUS;
                  sym_kind_o  <= K_STATUS;
                  sym_ticks_o <= w_status_ticks;
                  r_acc       <= r_acc + w_status_ticks;
               end
               S_STATUS: begin
                  r_state     <= S_DATA;
                  sym_kind_o  <= K_DATA;
                  sym_ticks_o <= w_cur_ticks;
                  r_acc       <= r_acc + w_cur_ticks;
               end
               S_DATA: begin
                  r_crc <= w_crc_upd;
                  if (w_nib_last) begin
                     r_state     <= S_CRC;
                     sym_kind_o  <= K_CRC;
                     sym_ticks_o <= w_crc_ticks;
                     r_acc       <= r_acc + w_crc_ticks;
                  end else begin
                     r_nib_idx   <= r_nib_idx + 3'd1;
                     sym_ticks_o <= w_next_ticks;
                     r_acc       <= r_acc + w_next_ticks;
                  end
               end
               S_CRC: begin
                  r_state     <= S_PAUSE;
                  sym_kind_o  <= K_PAUSE;
                  sym_ticks_o <= w_pause_ticks;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sent_tx_frame_seq.sv
// Directed bench for sent_tx_frame_seq: hand-computed symbol sequences and CRCs,
// pause modes, back-to-back frames, backpressure, illegal lengths and reset abort.
module tb_sent_tx_frame_seq;

   logic        clk_tx = 1'b0;
   logic        reset_n_tx;
   logic        frame_valid_i;
   logic        frame_ready_o;
   logic [23:0] frame_data_i;
   logic [2:0]  frame_len_i;
   logic [3:0]  status_i;
   logic [1:0]  pause_mode_i;
   logic [9:0]  pause_ticks_i;
   logic        sym_valid_o;
   logic        sym_ready_i;
   logic [2:0]  sym_kind_o;
   logic [9:0]  sym_ticks_o;
   logic        busy_o;
   logic        frame_done_o;
   logic        err_len_o;

   sent_tx_frame_seq #(.MAX_NIB(6), .TICK_W(10)) dut (
      .clk_tx        (clk_tx),
      .reset_n_tx    (reset_n_tx),
      .frame_valid_i (frame_valid_i),
      .frame_ready_o (frame_ready_o),
      .frame_data_i  (frame_data_i),
      .frame_len_i   (frame_len_i),
      .status_i      (status_i),
      .pause_mode_i  (pause_mode_i),
      .pause_ticks_i (pause_ticks_i),
      .sym_valid_o   (sym_valid_o),
      .sym_ready_i   (sym_ready_i),
      .sym_kind_o    (sym_kind_o),
      .sym_ticks_o   (sym_ticks_o),
      .busy_o        (busy_o),
      .frame_done_o  (frame_done_o),
      .err_len_o     (err_len_o)
   );

   always #5 clk_tx = ~clk_tx;

   int checks = 0;
   int errors = 0;

   int n_acc = 0, n_done = 0, n_err = 0, n_zero_gap = 0, stall_viol = 0, max_res = 0, res;
   logic       p_stall = 1'b0;
   logic [2:0] p_kind;
   logic [9:0] p_ticks;
   logic [2:0] q_kind[$];
   logic [9:0] q_ticks[$];

   logic [23:0] f_data[4];
   logic [2:0]  f_len[4];
   logic [3:0]  f_st[4];
   logic [1:0]  f_mode[4];
   logic [9:0]  f_pt[4];

   // Hand-computed sequences (kind, ticks) for the three reference frames.
   int f1_k[9] = '{0, 1, 2, 2, 2, 2, 2, 2, 3};
   int f1_t[9] = '{56, 15, 13, 14, 15, 16, 17, 18, 13};
   int f2_k[6] = '{0, 1, 2, 2, 2, 3};
   int f2_t[6] = '{56, 12, 27, 12, 20, 14};
   int f3_k[5] = '{0, 1, 2, 2, 3};
   int f3_t[5] = '{56, 27, 22, 15, 24};
   int s_k[4]  = '{0, 1, 2, 3};
   int s_t[4]  = '{56, 12, 12, 22};

   // Observation at the falling edge: what is seen here is what the next rising edge commits.
   always @(negedge clk_tx) begin
      if (reset_n_tx) begin
         if (frame_valid_i && frame_ready_o) n_acc++;
         if (sym_valid_o && sym_ready_i) begin
            q_kind.push_back(sym_kind_o);
            q_ticks.push_back(sym_ticks_o);
         end
         if (frame_done_o) n_done++;
         if (err_len_o) n_err++;
         if (frame_done_o && sym_valid_o && sym_kind_o == 3'd0) n_zero_gap++;
         if (p_stall && (!sym_valid_o || sym_kind_o != p_kind || sym_ticks_o != p_ticks)) stall_viol++;
         res = int'(!frame_ready_o) + int'(busy_o);
         if (res > max_res) max_res = res;
         p_stall = sym_valid_o && !sym_ready_i;
         p_kind  = sym_kind_o;
         p_ticks = sym_ticks_o;
      end else begin
         p_stall = 1'b0;
      end
   end

   task automatic set_slot(input int s, input logic [23:0] d, input logic [2:0] l,
                           input logic [3:0] st, input logic [1:0] m, input logic [9:0] pt);
      f_data[s] = d; f_len[s] = l; f_st[s] = st; f_mode[s] = m; f_pt[s] = pt;
   endtask

   task automatic drive_slot(input int s);
      frame_data_i  = f_data[s];
      frame_len_i   = f_len[s];
      status_i      = f_st[s];
      pause_mode_i  = f_mode[s];
      pause_ticks_i = f_pt[s];
      frame_valid_i = 1'b1;
   endtask

   task automatic run_frames(input int nf, input int dn, input int en, input bit rnd);
      int idx = 0;
      int cyc = 0;
      int a0 = n_acc;
      int d0 = n_done;
      int e0 = n_err;
      drive_slot(0);
      while ((idx < nf || (n_done - d0) < dn || (n_err - e0) < en) && cyc < 2000) begin
         @(posedge clk_tx); #1;
         cyc++;
         if ((n_acc - a0) > idx) begin
            idx++;
            if (idx < nf) drive_slot(idx);
            else frame_valid_i = 1'b0;
         end
         if (rnd) sym_ready_i = 1'($urandom_range(0, 1));
      end
      frame_valid_i = 1'b0;
      sym_ready_i   = 1'b1;
      checks++;
      if (cyc >= 2000) begin
         errors++;
         $display("FAIL run_frames timeout: got %0d cycles, required < 2000", cyc);
      end
      repeat (3) @(posedge clk_tx);
      #1;
   endtask

   task automatic test_reset();
      reset_n_tx = 1'b0; frame_valid_i = 1'b0; frame_data_i = '0; frame_len_i = '0;
      status_i = '0; pause_mode_i = '0; pause_ticks_i = '0; sym_ready_i = 1'b1;
      #3;
      checks++;
      if (frame_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset got %b want 0", frame_ready_o); end
      repeat (3) @(posedge clk_tx);
      #1 reset_n_tx = 1'b1;
      @(posedge clk_tx); #1;
      checks++;
      if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", frame_ready_o); end
      checks++;
      if (sym_valid_o !== 1'b0 || sym_kind_o !== 3'd0 || sym_ticks_o !== 10'd0) begin
         errors++; $display("FAIL reset_sym got v=%b k=%0d t=%0d want 0/0/0", sym_valid_o, sym_kind_o, sym_ticks_o);
      end
      checks++;
      if (busy_o !== 1'b0 || frame_done_o !== 1'b0 || err_len_o !== 1'b0) begin
         errors++; $display("FAIL reset_flags got busy=%b done=%b err=%b want 0", busy_o, frame_done_o, err_len_o);
      end
   endtask

   task automatic test_single();
      int cyc = 0;
      int a0 = n_acc;
      int d0 = n_done;
      q_kind.delete(); q_ticks.delete();
      set_slot(0, 24'h000000, 3'd1, 4'h0, 2'b00, 10'd0);
      drive_slot(0);
      while (n_acc == a0 && cyc < 20) begin @(posedge clk_tx); #1; cyc++; end
      frame_valid_i = 1'b0;
      checks++;
      if (frame_ready_o !== 1'b0 || sym_valid_o !== 1'b0) begin
         errors++; $display("FAIL single_hold_cycle got ready=%b valid=%b want 0/0", frame_ready_o, sym_valid_o);
      end
      @(posedge clk_tx); #1;
      checks++;
      if (sym_valid_o !== 1'b1 || sym_kind_o !== 3'd0 || sym_ticks_o !== 10'd56 || busy_o !== 1'b1 || frame_ready_o !== 1'b1) begin
         errors++; $display("FAIL single_sync_latency got v=%b k=%0d t=%0d busy=%b ready=%b want 1/0/56/1/1",
                            sym_valid_o, sym_kind_o, sym_ticks_o, busy_o, frame_ready_o);
      end
      cyc = 0;
      while (n_done == d0 && cyc < 50) begin @(posedge clk_tx); #1; cyc++; end
      repeat (2) @(posedge clk_tx);
      #1;
      checks++;
      if (n_done - d0 !== 1 || busy_o !== 1'b0) begin
         errors++; $display("FAIL single_done got pulses=%0d busy=%b want 1/0", n_done - d0, busy_o);
      end
      checks++;
      if (q_kind.size() !== 4) begin errors++; $display("FAIL single_count got %0d want 4", q_kind.size()); end
      for (int i = 0; i < 4 && i < q_kind.size(); i++) begin
         checks++;
         if (q_kind[i] !== 3'(s_k[i]) || q_ticks[i] !== 10'(s_t[i])) begin
            errors++; $display("FAIL single_sym%0d got %0d/%0d want %0d/%0d", i, q_kind[i], q_ticks[i], s_k[i], s_t[i]);
         end
      end
   endtask

   task automatic test_pause();
      logic [1:0] md[8] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
      int         pt[8] = '{300, 100, 5, 40, 115, 113, 300, 300};
      int         ep[8] = '{198, 12, 12, 40, 13, 12, 0, 0};
      for (int c = 0; c < 8; c++) begin
         q_kind.delete(); q_ticks.delete();
         set_slot(0, 24'h000000, 3'd1, 4'h0, md[c], 10'(pt[c]));
         run_frames(1, 1, 0, 1'b0);
         checks++;
         if (q_kind.size() !== ((ep[c] == 0) ? 4 : 5)) begin
            errors++; $display("FAIL pause%0d_count got %0d want %0d", c, q_kind.size(), (ep[c] == 0) ? 4 : 5);
         end else begin
            checks++;
            if (q_ticks[3] !== 10'd22) begin errors++; $display("FAIL pause%0d_crc got %0d want 22", c, q_ticks[3]); end
            if (ep[c] != 0) begin
               checks++;
               if (q_kind[4] !== 3'd4 || q_ticks[4] !== 10'(ep[c])) begin
                  errors++; $display("FAIL pause%0d_sym got %0d/%0d want 4/%0d", c, q_kind[4], q_ticks[4], ep[c]);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int ek[$];
      int et[$];
      int z0 = n_zero_gap;
      for (int i = 0; i < 9; i++) begin ek.push_back(f1_k[i]); et.push_back(f1_t[i]); end
      for (int i = 0; i < 6; i++) begin ek.push_back(f2_k[i]); et.push_back(f2_t[i]); end
      for (int i = 0; i < 5; i++) begin ek.push_back(f3_k[i]); et.push_back(f3_t[i]); end
      q_kind.delete(); q_ticks.delete();
      max_res = 0;
      set_slot(0, 24'h123456, 3'd6, 4'h3, 2'b00, 10'd0);
      set_slot(1, 24'hF08000, 3'd3, 4'h0, 2'b00, 10'd0);
      set_slot(2, 24'hA30000, 3'd2, 4'hF, 2'b00, 10'd0);
      run_frames(3, 3, 0, 1'b0);
      checks++;
      if (n_zero_gap - z0 !== 2) begin errors++; $display("FAIL b2b_zero_gap got %0d want 2", n_zero_gap - z0); end
      checks++;
      if (max_res !== 2) begin errors++; $display("FAIL b2b_resident got %0d want 2", max_res); end
      checks++;
      if (q_kind.size() !== 20) begin errors++; $display("FAIL b2b_count got %0d want 20", q_kind.size()); end
      for (int i = 0; i < 20 && i < q_kind.size(); i++) begin
         checks++;
         if (q_kind[i] !== 3'(ek[i]) || q_ticks[i] !== 10'(et[i])) begin
            errors++; $display("FAIL b2b_sym%0d got %0d/%0d want %0d/%0d", i, q_kind[i], q_ticks[i], ek[i], et[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int s0 = stall_viol;
      q_kind.delete(); q_ticks.delete();
      set_slot(0, 24'h123456, 3'd6, 4'h3, 2'b00, 10'd0);
      set_slot(1, 24'hF08000, 3'd3, 4'h0, 2'b00, 10'd0);
      run_frames(2, 2, 0, 1'b1);
      checks++;
      if (stall_viol - s0 !== 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stall_viol - s0); end
      checks++;
      if (q_kind.size() !== 15) begin errors++; $display("FAIL bp_count got %0d want 15", q_kind.size()); end
      for (int i = 0; i < 15 && i < q_kind.size(); i++) begin
         checks++;
         if (q_kind[i] !== 3'((i < 9) ? f1_k[i] : f2_k[i-9]) || q_ticks[i] !== 10'((i < 9) ? f1_t[i] : f2_t[i-9])) begin
            errors++; $display("FAIL bp_sym%0d got %0d/%0d", i, q_kind[i], q_ticks[i]);
         end
      end
   endtask

   task automatic test_illegal_len();
      int e0 = n_err;
      q_kind.delete(); q_ticks.delete();
      set_slot(0, 24'h111111, 3'd0, 4'h0, 2'b00, 10'd0);
      set_slot(1, 24'h222222, 3'd7, 4'h0, 2'b00, 10'd0);
      set_slot(2, 24'h000000, 3'd1, 4'h0, 2'b00, 10'd0);
      run_frames(3, 1, 2, 1'b0);
      checks++;
      if (n_err - e0 !== 2) begin errors++; $display("FAIL illegal_err_pulses got %0d want 2", n_err - e0); end
      checks++;
      if (q_kind.size() !== 4) begin errors++; $display("FAIL illegal_count got %0d want 4", q_kind.size()); end
      for (int i = 0; i < 4 && i < q_kind.size(); i++) begin
         checks++;
         if (q_kind[i] !== 3'(s_k[i]) || q_ticks[i] !== 10'(s_t[i])) begin
            errors++; $display("FAIL illegal_sym%0d got %0d/%0d want %0d/%0d", i, q_kind[i], q_ticks[i], s_k[i], s_t[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int idx = 0;
      int cyc = 0;
      int a0 = n_acc;
      q_kind.delete(); q_ticks.delete();
      set_slot(0, 24'h123456, 3'd6, 4'h3, 2'b00, 10'd0);
      set_slot(1, 24'hF08000, 3'd3, 4'h0, 2'b00, 10'd0);
      drive_slot(0);
      while (q_kind.size() < 4 && cyc < 200) begin
         @(posedge clk_tx); #1;
         cyc++;
         if ((n_acc - a0) > idx) begin
            idx++;
            if (idx < 2) drive_slot(idx);
            else frame_valid_i = 1'b0;
         end
      end
      frame_valid_i = 1'b0;
      checks++;
      if (sym_kind_o !== 3'd2 || sym_ticks_o !== 10'd15 || frame_ready_o !== 1'b0) begin
         errors++; $display("FAIL rmid_setup got k=%0d t=%0d ready=%b want 2/15/0", sym_kind_o, sym_ticks_o, frame_ready_o);
      end
      #2 reset_n_tx = 1'b0;
      #1;
      checks++;
      if (sym_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL rmid_abort got valid=%b busy=%b want 0/0", sym_valid_o, busy_o);
      end
      @(posedge clk_tx); #1 reset_n_tx = 1'b1;
      @(posedge clk_tx); #1;
      checks++;
      if (frame_ready_o !== 1'b1 || busy_o !== 1'b0 || sym_valid_o !== 1'b0) begin
         errors++; $display("FAIL rmid_after got ready=%b busy=%b valid=%b want 1/0/0", frame_ready_o, busy_o, sym_valid_o);
      end
      q_kind.delete(); q_ticks.delete();
      set_slot(0, 24'hA30000, 3'd2, 4'hF, 2'b00, 10'd0);
      run_frames(1, 1, 0, 1'b0);
      checks++;
      if (q_kind.size() !== 5) begin errors++; $display("FAIL rmid_count got %0d want 5", q_kind.size()); end
      for (int i = 0; i < 5 && i < q_kind.size(); i++) begin
         checks++;
         if (q_kind[i] !== 3'(f3_k[i]) || q_ticks[i] !== 10'(f3_t[i])) begin
            errors++; $display("FAIL rmid_sym%0d got %0d/%0d want %0d/%0d", i, q_kind[i], q_ticks[i], f3_k[i], f3_t[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_pause();
      test_back_to_back();
      test_backpressure();
      test_illegal_len();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
